// File: rtl/vec_cache_tag_dirty_array_mp.sv
// ---------------------------------------------------------------------------
// vec_cache_tag_dirty_array_mp
// Multi-port tag/dirty array for a vector cache. Each port may read or
// masked-write one entry per cycle. Every accepted access returns the entry's
// pre-access value one cycle later. The array is never reset directly. After
// reset, and on request, a sweep writes INIT_VALUE into every entry, one
// entry per cycle.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req_vld/wr      per-port request valid and write flag
//   req_addr        per-port entry index
//   req_wdata/wmask per-port write data and per-bit write enable
//   req_rdy         requests are accepted (low during the sweep)
//   rd_vld/rd_data  per-port response, one cycle after acceptance
//   init_start      pulse that starts a re-initialisation sweep
//   init_busy       sweep in progress
//   init_done       pulse in the cycle the last entry is swept
//   wr_collision    pulse: several ports wrote one address in the prior cycle
// ---------------------------------------------------------------------------
module vec_cache_tag_dirty_array_mp #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned NUM_PORTS  = 2,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_PORTS-1:0]                  req_vld,
    input  logic [NUM_PORTS-1:0]                  req_wr,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_wdata,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  req_wmask,
    output logic                                  req_rdy,
    output logic [NUM_PORTS-1:0]                  rd_vld,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  rd_data,
    input  logic                                  init_start,
    output logic                                  init_busy,
    output logic                                  init_done,
    output logic                                  wr_collision
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_INIT = 1'b1
    } state_e;

    state_e                                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]                  idx_q, idx_d;
    logic                                   rdy_q, busy_q;
    logic                                   done_q, done_d;
    logic                                   coll_q, coll_d;
    logic [NUM_PORTS-1:0]                   rd_vld_q;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   rd_data_q;

    logic [NUM_PORTS-1:0]                   acc;
    logic [NUM_PORTS-1:0]                   wr_en;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   wr_val;

    logic [DATA_WIDTH-1:0]                  mem [DEPTH];

    // Request acceptance
    always_comb begin
        acc   = req_vld & {NUM_PORTS{rdy_q}};
        wr_en = acc & req_wr;
    end

    // Sweep FSM: next state, sweep index and registered-output decodes
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (init_start) begin
                    state_d = ST_INIT;
                    idx_d   = '0;
                end
            end
            ST_INIT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_INIT;
                idx_d   = '0;
            end
        endcase
        // Registered one cycle early so the pulse lines up with the last sweep write
        done_d = (state_d == ST_INIT) && (idx_d == LAST_IDX);
    end

    // Write merge: every port writing an address computes the same fully merged
    // value, so same-address writes resolve bitwise with the highest port winning.
    always_comb begin
        wr_val = '0;
        coll_d = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            wr_val[p] = mem[req_addr[p]];
            for (int q = 0; q < NUM_PORTS; q++) begin
                if (wr_en[q] && (req_addr[q] == req_addr[p])) begin
                    wr_val[p] = (wr_val[p] & ~req_wmask[q]) | (req_wdata[q] & req_wmask[q]);
                end
            end
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int q = p + 1; q < NUM_PORTS; q++) begin
                if (wr_en[p] && wr_en[q] && (req_addr[p] == req_addr[q])) begin
                    coll_d = 1'b1;
                end
            end
        end
    end

    // Control and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            idx_q     <= '0;
            rdy_q     <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            coll_q    <= 1'b0;
            rd_vld_q  <= '0;
            rd_data_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rdy_q    <= (state_d == ST_IDLE);
            busy_q   <= (state_d == ST_INIT);
            done_q   <= done_d;
            coll_q   <= coll_d;
            rd_vld_q <= acc;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (acc[p]) begin
                    rd_data_q[p] <= mem[req_addr[p]];
                end
            end
        end
    end

    // Storage: no reset; contents come from the sweep or port writes
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem[idx_q] <= INIT_VALUE;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (wr_en[p]) begin
                    mem[req_addr[p]] <= wr_val[p];
                end
            end
        end
    end

    assign req_rdy      = rdy_q;
    assign init_busy    = busy_q;
    assign init_done    = done_q;
    assign wr_collision = coll_q;
    assign rd_vld       = rd_vld_q;
    assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_vec_cache_tag_dirty_array_mp.sv
// ---------------------------------------------------------------------------
// tb_vec_cache_tag_dirty_array_mp
// Directed bench for vec_cache_tag_dirty_array_mp. It uses a 16-entry,
// 4-bit, 2-port configuration with INIT_VALUE 4'hA.
// ---------------------------------------------------------------------------
module tb_vec_cache_tag_dirty_array_mp;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 4;
    localparam int unsigned NP = 2;

    logic                     clk;
    logic                     rst_n;
    logic [NP-1:0]            req_vld;
    logic [NP-1:0]            req_wr;
    logic [NP-1:0][AW-1:0]    req_addr;
    logic [NP-1:0][DW-1:0]    req_wdata;
    logic [NP-1:0][DW-1:0]    req_wmask;
    logic                     req_rdy;
    logic [NP-1:0]            rd_vld;
    logic [NP-1:0][DW-1:0]    rd_data;
    logic                     init_start;
    logic                     init_busy;
    logic                     init_done;
    logic                     wr_collision;

    int n_chk;
    int n_pass;

    vec_cache_tag_dirty_array_mp #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_PORTS  (NP),
        .INIT_VALUE (4'hA)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_vld      (req_vld),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_wmask    (req_wmask),
        .req_rdy      (req_rdy),
        .rd_vld       (rd_vld),
        .rd_data      (rd_data),
        .init_start   (init_start),
        .init_busy    (init_busy),
        .init_done    (init_done),
        .wr_collision (wr_collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Step past the next rising edge; outputs are then stable for sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ports();
        req_vld   = '0;
        req_wr    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
    endtask

    task automatic drive(input int p, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] m);
        req_vld[p]   = 1'b1;
        req_wr[p]    = wr;
        req_addr[p]  = a;
        req_wdata[p] = d;
        req_wmask[p] = m;
    endtask

    // Count init_busy samples and the sample index of the init_done pulse after reset release
    task automatic sweep_after_release(input string tag);
        int n_busy;
        int n_done;
        int done_at;
        n_busy  = 0;
        n_done  = 0;
        done_at = 0;
        for (int c = 1; c <= 40; c++) begin
            if (init_busy) n_busy++;
            if (init_done) begin
                n_done++;
                done_at = c;
            end
            tick();
        end
        check({tag, "_busy_cycles"}, 32'(n_busy), 32'd16);
        check({tag, "_done_cycle"}, 32'(done_at), 32'd16);
        check({tag, "_done_pulses"}, 32'(n_done), 32'd1);
        check({tag, "_rdy_after"}, 32'(req_rdy), 32'd1);
    endtask

    initial begin
        int n_low;
        int vld_seen;
        int done_seen;

        n_chk      = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        init_start = 1'b0;
        idle_ports();

        // Reset values, with a request pending that must be ignored
        drive(0, 1'b0, 4'd1, 4'h0, 4'h0);
        tick();
        tick();
        check("rst_busy", 32'(init_busy), 32'd1);
        check("rst_rdy", 32'(req_rdy), 32'd0);
        check("rst_rd_vld", 32'(rd_vld), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_done", 32'(init_done), 32'd0);
        check("rst_coll", 32'(wr_collision), 32'd0);
        idle_ports();
        rst_n = 1'b1;
        sweep_after_release("sweep1");

        // Read of a swept entry, then response hold
        drive(0, 1'b0, 4'd3, 4'h0, 4'h0);
        tick();
        idle_ports();
        check("rd3_vld", 32'(rd_vld), 32'b01);
        check("rd3_data", 32'(rd_data[0]), 32'hA);
        tick();
        check("rd3_vld_drop", 32'(rd_vld), 32'b00);
        check("rd3_data_hold", 32'(rd_data[0]), 32'hA);

        // Masked write returns old value; merged value read back
        drive(0, 1'b1, 4'd5, 4'h3, 4'h3);
        tick();
        idle_ports();
        check("wr5_old", 32'(rd_data[0]), 32'hA);
        check("wr5_vld", 32'(rd_vld), 32'b01);
        drive(0, 1'b0, 4'd5, 4'h0, 4'h0);
        tick();
        idle_ports();
        check("rd5_merged", 32'(rd_data[0]), 32'hB);

        // Same-address writes: bitwise highest port wins, collision pulse
        drive(0, 1'b1, 4'd2, 4'hF, 4'hF);
        drive(1, 1'b1, 4'd2, 4'h0, 4'hC);
        tick();
        idle_ports();
        check("coll_pulse", 32'(wr_collision), 32'd1);
        check("coll_old", 32'(rd_data), 32'hAA);
        tick();
        check("coll_clear", 32'(wr_collision), 32'd0);
        drive(1, 1'b0, 4'd2, 4'h0, 4'h0);
        tick();
        idle_ports();
        check("rd2_merged", 32'(rd_data[1]), 32'h3);
        check("rd2_vld", 32'(rd_vld), 32'b10);

        // Different-address writes raise no collision
        drive(0, 1'b1, 4'd8, 4'h1, 4'hF);
        drive(1, 1'b1, 4'd9, 4'h2, 4'hF);
        tick();
        idle_ports();
        check("nocoll", 32'(wr_collision), 32'd0);

        // Write and read of the same address: reader sees pre-write value
        drive(0, 1'b1, 4'd7, 4'h1, 4'hF);
        drive(1, 1'b0, 4'd7, 4'h0, 4'h0);
        tick();
        idle_ports();
        check("rbw_p1", 32'(rd_data[1]), 32'hA);
        check("rbw_p0", 32'(rd_data[0]), 32'hA);
        drive(1, 1'b0, 4'd7, 4'h0, 4'h0);
        tick();
        idle_ports();
        check("rd7_new", 32'(rd_data[1]), 32'h1);

        // Re-init with requests held: same-cycle requests complete, the rest stall
        init_start = 1'b1;
        drive(0, 1'b0, 4'd5, 4'h0, 4'h0);
        drive(1, 1'b1, 4'd6, 4'h0, 4'hF);
        tick();
        init_start = 1'b0;
        check("ini_same_vld", 32'(rd_vld), 32'b11);
        check("ini_same_rd5", 32'(rd_data[0]), 32'hB);
        check("ini_rdy_low", 32'(req_rdy), 32'd0);
        n_low     = 1;
        vld_seen  = 0;
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (init_done) done_seen++;
            tick();
            if (req_rdy) break;
            n_low++;
            if (rd_vld != '0) vld_seen++;
        end
        check("ini_rdy_low_cycles", 32'(n_low), 32'd16);
        check("ini_no_rd_vld", 32'(vld_seen), 32'd0);
        check("ini_done_seen", 32'(done_seen), 32'd1);
        check("ini_rd_vld_at_rdy", 32'(rd_vld), 32'b00);
        idle_ports();
        for (int a = 0; a < 16; a += 2) begin
            drive(0, 1'b0, AW'(a), 4'h0, 4'h0);
            drive(1, 1'b0, AW'(a + 1), 4'h0, 4'h0);
            tick();
            idle_ports();
            check($sformatf("ini_all_%0d", a), 32'(rd_data), 32'hAA);
        end

        // Reset in mid-sweep at index 9 restarts a full sweep
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        for (int c = 0; c < 9; c++) tick();
        check("mid_busy_pre", 32'(init_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(init_busy), 32'd1);
        check("mid_rst_rdy", 32'(req_rdy), 32'd0);
        check("mid_rst_rd_data", 32'(rd_data), 32'd0);
        check("mid_rst_rd_vld", 32'(rd_vld), 32'd0);
        check("mid_rst_done", 32'(init_done), 32'd0);
        tick();
        rst_n = 1'b1;
        sweep_after_release("sweep2");
        drive(0, 1'b0, 4'd15, 4'h0, 4'h0);
        tick();
        idle_ports();
        check("post_rst_rd15", 32'(rd_data[0]), 32'hA);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vec_cache_tag_dirty_array_mp.md
VEC_CACHE_TAG_DIRTY_ARRAY_MP -- requirements
Module: vec_cache_tag_dirty_array_mp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning entry index width; depth is 2**ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 4, meaning bits per entry (tag-dirty field).
REQ-003 SHALL have parameter NUM_PORTS, default 2, legal range 1..4, meaning independent access ports.
REQ-004 SHALL have parameter INIT_VALUE, default '0, DATA_WIDTH bits, meaning the value every entry holds after an init sweep.
REQ-005 clk  in  1  sole clock; all state on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 req_vld  in  [NUM_PORTS]  per-port access request.
REQ-008 req_wr  in  [NUM_PORTS]  1 = write, 0 = read.
REQ-009 req_addr  in  [NUM_PORTS][ADDR_WIDTH]  entry index.
REQ-010 req_wdata  in  [NUM_PORTS][DATA_WIDTH]  write data.
REQ-011 req_wmask  in  [NUM_PORTS][DATA_WIDTH]  per-bit write enable.
REQ-012 req_rdy  out  1  array accepts requests; shared by all ports.
REQ-013 rd_vld  out  [NUM_PORTS]  rd_data valid for that port.
REQ-014 rd_data  out  [NUM_PORTS][DATA_WIDTH]  pre-access entry contents.
REQ-015 init_start  in  1  single-cycle pulse requesting a re-initialisation sweep.
REQ-016 init_busy  out  1  init sweep in progress.
REQ-017 init_done  out  1  one-cycle pulse on the last sweep write.
REQ-018 wr_collision  out  1  one-cycle pulse: two or more ports wrote the same address in one accepted cycle.

Function
REQ-019 Port p request SHALL be accepted iff req_vld[p] and req_rdy are both high; unaccepted requests have no effect and produce no response.
REQ-020 req_rdy SHALL equal !init_busy.
REQ-021 Every accepted request (read or write) SHALL set rd_vld[p] and rd_data[p] exactly 1 cycle later; rd_data is the entry value before any write of that cycle (read-before-write, across all ports).
REQ-022 rd_vld[p] SHALL be low in any cycle following no accepted request on port p; rd_data[p] holds its last value.
REQ-023 An accepted write SHALL update only the bits with req_wmask set; other bits keep their value.
REQ-024 For same-address writes in one cycle, each bit SHALL take the data of the highest-index port whose mask bit is set; wr_collision pulses the next cycle whether or not masks overlap.
REQ-025 FSM states SHALL be IDLE and INIT; IDLE->INIT on init_start; INIT->IDLE after the entry at index 2**ADDR_WIDTH-1 is written.
REQ-026 In INIT, one entry per cycle SHALL be written with INIT_VALUE, index counting 0 to 2**ADDR_WIDTH-1 with no wrap; a sweep lasts exactly 2**ADDR_WIDTH cycles.
REQ-027 init_busy SHALL be high exactly while in INIT; init_done pulses in the cycle the last index is written.
REQ-028 init_start SHALL be ignored while in INIT; requests accepted in the same cycle as init_start SHALL complete normally, with their writes then overwritten by the sweep.
REQ-029 Array storage SHALL NOT be directly reset; initial contents come only from the sweep.

Reset
REQ-030 While rst_n is low: state INIT, sweep index 0, init_busy 1, req_rdy 0, rd_vld 0, rd_data 0, init_done 0, wr_collision 0.
REQ-031 The first rising edge after rst_n deasserts SHALL begin the sweep at index 0; reset asserted mid-sweep or mid-access SHALL restart the sweep from 0 and discard in-flight responses.

Verification (ADDR_WIDTH=4, DATA_WIDTH=4, NUM_PORTS=2, INIT_VALUE=4'hA)
REQ-032 Release reset -> init_busy high 16 cycles, init_done pulses on cycle 16; a port 0 read of addr 3 then returns 4'hA one cycle later.
REQ-033 Port 0 writes addr 5 data 4'h3 mask 4'h3 -> rd_data[0]=4'hA next cycle; a later read of addr 5 returns 4'hB.
REQ-034 Same cycle: port 0 writes addr 2 data 4'hF mask 4'hF and port 1 writes addr 2 data 4'h0 mask 4'hC -> wr_collision pulses; addr 2 reads 4'h3.
REQ-035 Same cycle: port 0 writes addr 7 data 4'h1 and port 1 reads addr 7 -> rd_data[1]=4'hA; the next read returns 4'h1.
REQ-036 init_start pulse in IDLE with reqs held -> req_rdy low 16 cycles, no rd_vld; all entries read 4'hA after init_done.
REQ-037 Assert rst_n low at sweep index 9 -> outputs return to reset values; after release a full 16-cycle sweep runs again.
